// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the
// instruction memory boot loader.
package inst_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the loader owns the stream
  function automatic logic is_active(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA)   || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Big-endian 4-byte assembler; emits a
// word strobe on the fourth accepted byte.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE =
    2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  // Shift the next byte in, oldest byte ends up in the MSBs
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (en) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], din};
    end
  end

  assign word_valid = en && !clr &&
                      (cnt_q == LAST_BYTE);
  assign word       = {sr_q, din};

  // Counter and shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: length header, big-endian words,
// XOR checksum; writes instruction RAM in order.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  words_loaded
);

  localparam logic [LEN_W-1:0] DEPTH_L =
    LEN_W'(DEPTH);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [8:0]        wl_q, wl_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rdy_q, busy_q;
  logic              done_q, err_q;
  logic              accept;
  logic              pk_clr, pk_en;
  logic              word_valid;
  logic [31:0]       word;

  assign accept = rx_valid && rdy_q;
  assign pk_en  = accept && (state_q == ST_DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .en         (pk_en),
    .din        (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state, header/checksum tracking and RAM write issue
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pk_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          csum_d  = '0;
          wl_d    = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data, 8'h00};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = {len_q[15:8], rx_data};
          if (len_d == '0 || len_d > DEPTH_L)
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept)
          csum_d = csum_q ^ rx_data;
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR +
                    {21'b0, wl_q, 2'b00};
          wdata_d = word;
          wl_d    = wl_q + 9'd1;
          if ({7'b0, wl_d} == len_q)
            state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept)
          state_d = (rx_data == csum_q) ?
                    ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= is_active(state_d);
      busy_q  <= is_active(state_d);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign rx_ready     = rdy_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader with an
// image-level reference model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_loaded;

  inst_mem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  logic [31:0] exp_words[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] ref_addr[$];
  logic [31:0] ref_data[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic rand_words(input int n);
    exp_words.delete();
    for (int k = 0; k < n; k++)
      exp_words.push_back($urandom);
  endtask

  // Stream image: header, words MSB first, XOR checksum
  task automatic make_image(input int len, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    tx_q.delete();
    tx_q.push_back(8'((len >> 8) & 255));
    tx_q.push_back(8'(len & 255));
    foreach (exp_words[k]) begin
      for (int j = 3; j >= 0; j--) begin
        b = exp_words[k][8*j +: 8];
        tx_q.push_back(b);
        cs = cs ^ b;
      end
    end
    if (exp_words.size() > 0)
      tx_q.push_back(bad ? (cs ^ 8'hFE) : cs);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int thr, input int start_idx,
                      output bit timed_out);
    int  idx;
    int  n;
    bit  fired;
    idx = 0;
    n = 0;
    fired = 1'b0;
    while (idx < tx_q.size() && n < 20000) begin
      @(negedge clk);
      start = (!fired && idx == start_idx);
      if (start) fired = 1'b1;
      rx_data  = tx_q[idx];
      rx_valid = ($urandom_range(99) < thr);
      if (rx_valid && rx_ready) idx++;
      n++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b0;
    timed_out = (idx < tx_q.size());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    idle(3);
    chk_cnt++;
    if ({rx_ready, mem_we, busy, done, err} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000",
               {rx_ready, mem_we, busy, done, err});
    else pass_cnt++;
    chk_cnt++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_mem got=%h/%h want=0/0",
               mem_addr, mem_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (words_loaded !== 9'd0)
      $display("FAIL reset_wl got=%0d want=0", words_loaded);
    else pass_cnt++;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic(input bit bad);
    bit to;
    exp_words.delete();
    exp_words.push_back(32'h2008_0000);
    exp_words.push_back(32'h2009_0000);
    make_image(2, bad);
    clear_writes();
    do_start();
    chk_cnt++;
    if ({busy, rx_ready, done, err} !== 4'b1100)
      $display("FAIL start_flags got=%b want=1100",
               {busy, rx_ready, done, err});
    else pass_cnt++;
    send(100, -1, to);
    idle(2);
    chk_cnt++;
    if (to !== 1'b0 || wr_addr.size() != 2)
      $display("FAIL basic_cnt got=%0d to=%0d want=2",
               wr_addr.size(), to);
    else pass_cnt++;
    for (int k = 0; k < wr_addr.size() && k < 2; k++) begin
      chk_cnt++;
      if (wr_addr[k] !== 32'(4*k) ||
          wr_data[k] !== exp_words[k])
        $display("FAIL basic_wr%0d got=%h:%h want=%h:%h", k,
                 wr_addr[k], wr_data[k], 32'(4*k), exp_words[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({done, err, busy} !== (bad ? 3'b010 : 3'b100))
      $display("FAIL basic_flags bad=%0d got=%b want=%b", bad,
               {done, err, busy}, bad ? 3'b010 : 3'b100);
    else pass_cnt++;
    chk_cnt++;
    if (words_loaded !== 9'd2)
      $display("FAIL basic_wl got=%0d want=2", words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_bad_len();
    bit to;
    int lens[2];
    lens[0] = 0;
    lens[1] = 257;
    foreach (lens[i]) begin
      exp_words.delete();
      make_image(lens[i], 1'b0);
      clear_writes();
      do_start();
      send(100, -1, to);
      idle(3);
      chk_cnt++;
      if (to !== 1'b0 || wr_addr.size() != 0)
        $display("FAIL badlen_wr len=%0d got=%0d want=0",
                 lens[i], wr_addr.size());
      else pass_cnt++;
      chk_cnt++;
      if ({done, err, busy, rx_ready} !== 4'b0100)
        $display("FAIL badlen_flags len=%0d got=%b want=0100",
                 lens[i], {done, err, busy, rx_ready});
      else pass_cnt++;
      chk_cnt++;
      if (words_loaded !== 9'd0)
        $display("FAIL badlen_wl len=%0d got=%0d want=0",
                 lens[i], words_loaded);
      else pass_cnt++;
    end
  endtask

  task automatic test_full();
    bit to;
    int bad_wr;
    int min_gap;
    rand_words(256);
    make_image(256, 1'b0);
    clear_writes();
    do_start();
    send(100, -1, to);
    idle(2);
    chk_cnt++;
    if (to !== 1'b0 || wr_addr.size() != 256)
      $display("FAIL full_cnt got=%0d to=%0d want=256",
               wr_addr.size(), to);
    else pass_cnt++;
    bad_wr = 0;
    min_gap = 1000;
    for (int k = 0; k < wr_addr.size() && k < 256; k++) begin
      if (wr_addr[k] !== 32'(4*k) ||
          wr_data[k] !== exp_words[k])
        bad_wr++;
      if (k > 0 && wr_cyc[k] - wr_cyc[k-1] < min_gap)
        min_gap = wr_cyc[k] - wr_cyc[k-1];
    end
    chk_cnt++;
    if (bad_wr != 0)
      $display("FAIL full_data got=%0d bad writes want=0",
               bad_wr);
    else pass_cnt++;
    chk_cnt++;
    if (wr_addr.size() == 0 ||
        wr_addr[wr_addr.size()-1] !== 32'h3FC)
      $display("FAIL full_last got=%0d writes want=last 3fc",
               wr_addr.size());
    else pass_cnt++;
    chk_cnt++;
    if (min_gap < 4)
      $display("FAIL full_gap got=%0d want>=4", min_gap);
    else pass_cnt++;
    chk_cnt++;
    if ({done, err, busy} !== 3'b100 ||
        words_loaded !== 9'd256)
      $display("FAIL full_end got=%b wl=%0d want=100 wl=256",
               {done, err, busy}, words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_throttle();
    bit to;
    rand_words(3);
    make_image(3, 1'b0);
    clear_writes();
    do_start();
    send(100, -1, to);
    idle(2);
    ref_addr = wr_addr;
    ref_data = wr_data;
    clear_writes();
    do_start();
    send(50, 6, to);
    idle(2);
    chk_cnt++;
    if (to !== 1'b0 || wr_addr.size() != 3 ||
        ref_addr.size() != 3)
      $display("FAIL thr_cnt got=%0d/%0d to=%0d want=3/3",
               wr_addr.size(), ref_addr.size(), to);
    else pass_cnt++;
    for (int k = 0; k < wr_addr.size() && k < 3 &&
                    k < ref_addr.size(); k++) begin
      chk_cnt++;
      if (wr_addr[k] !== ref_addr[k] ||
          wr_data[k] !== ref_data[k] ||
          wr_addr[k] !== 32'(4*k) ||
          wr_data[k] !== exp_words[k])
        $display("FAIL thr_wr%0d got=%h:%h want=%h:%h", k,
                 wr_addr[k], wr_data[k], 32'(4*k), exp_words[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({done, err, busy} !== 3'b100 ||
        words_loaded !== 9'd3)
      $display("FAIL thr_end got=%b wl=%0d want=100 wl=3",
               {done, err, busy}, words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to;
    rand_words(2);
    make_image(2, 1'b0);
    while (tx_q.size() > 8) void'(tx_q.pop_back());
    clear_writes();
    do_start();
    send(100, -1, to);
    #1 rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({rx_ready, mem_we, busy, done, err} !== 5'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        words_loaded !== 9'd0)
      $display("FAIL rstmid got=%b %h %h %0d want=0 0 0 0",
               {rx_ready, mem_we, busy, done, err},
               mem_addr, mem_wdata, words_loaded);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rand_words(1);
    make_image(1, 1'b0);
    clear_writes();
    do_start();
    send(100, -1, to);
    idle(2);
    chk_cnt++;
    if (to !== 1'b0 || wr_addr.size() != 1 ||
        wr_addr[0] !== 32'h0 || wr_data[0] !== exp_words[0])
      $display("FAIL rstmid_wr got=%0d writes want=1 at 0",
               wr_addr.size());
    else pass_cnt++;
    chk_cnt++;
    if ({done, err, busy} !== 3'b100 ||
        words_loaded !== 9'd1)
      $display("FAIL rstmid_end got=%b wl=%0d want=100 wl=1",
               {done, err, busy}, words_loaded);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_bad_len();
    test_full();
    test_throttle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
